// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer and radix-2 datapath for the RV32M multiply/divide ops.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes; sign is applied on the last step.
module muldiv_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] data1,
   input  logic [DATA_WIDTH-1:0] data2,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
   typedef enum logic [2:0] {
      F_MUL, F_MULH, F_MULHSU, F_MULHU, F_DIV, F_DIVU, F_REM, F_REMU
   } funct_t;

   state_t                state, state_nx;
   funct_t                op_in, op_q;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] acc, lo, opb;
   logic                  neg_q;

   // Operand decode for the op being offered this cycle.
   logic                  s1, s2, in_neg, div_zero, div_ovf, bypass, accept, calc_step, last;
   logic [DATA_WIDTH-1:0] mag1, mag2, bypass_val;

   // Datapath step signals.
   logic [DATA_WIDTH:0]     mul_sum, shifted, diff;
   logic [DATA_WIDTH-1:0]   div_acc_nx, div_lo_nx, quo, remd, final_val;
   logic [2*DATA_WIDTH-1:0] prod_nx, prod_fix;
   logic                    div_ok;
   logic                    lint_unused;

   assign op_in       = funct_t'(alu_op[2:0]);
   assign lint_unused = ^{alu_op[4], prod_fix[DATA_WIDTH-1:0]};

   always_comb begin
      s1         = data1[DATA_WIDTH-1] && (op_in inside {F_MULH, F_MULHSU, F_DIV, F_REM});
      s2         = data2[DATA_WIDTH-1] && (op_in inside {F_MULH, F_DIV, F_REM});
      mag1       = s1 ? -data1 : data1;
      mag2       = s2 ? -data2 : data2;
      in_neg     = 1'b0;
      case (op_in)
         F_MULH, F_DIV:  in_neg = s1 ^ s2;
         F_MULHSU, F_REM: in_neg = s1;
         default:         in_neg = 1'b0;
      endcase
      div_zero   = op_in[2] && (data2 == '0);
      div_ovf    = (op_in inside {F_DIV, F_REM}) && (data1 == MIN_NEG) && (data2 == '1);
      bypass     = div_zero || div_ovf;
      bypass_val = '0;
      if (div_zero)
         bypass_val = (op_in inside {F_DIV, F_DIVU}) ? '1 : data1;
      else if (div_ovf)
         bypass_val = (op_in == F_DIV) ? MIN_NEG : '0;
   end

   always_comb begin
      // Multiply: {acc, lo} is the 2*DATA_WIDTH product register, multiplier shifting out of lo.
      mul_sum    = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
      prod_nx    = {mul_sum, lo[DATA_WIDTH-1:1]};
      prod_fix   = neg_q ? -prod_nx : prod_nx;
      // Divide: restoring step with a DATA_WIDTH+1 bit trial remainder; the top bit is the borrow.
      shifted    = {acc, lo[DATA_WIDTH-1]};
      diff       = shifted - {1'b0, opb};
      div_ok     = ~diff[DATA_WIDTH];
      div_acc_nx = div_ok ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
      div_lo_nx  = {lo[DATA_WIDTH-2:0], div_ok};
      quo        = neg_q ? -div_lo_nx : div_lo_nx;
      remd       = neg_q ? -div_acc_nx : div_acc_nx;
      case (op_q)
         F_MUL:                       final_val = prod_nx[DATA_WIDTH-1:0];
         F_MULH, F_MULHSU, F_MULHU:   final_val = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
         F_DIV, F_DIVU:               final_val = quo;
         default:                     final_val = remd;
      endcase
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      accept    = 1'b0;
      calc_step = 1'b0;
      last      = (count == CW'(DATA_WIDTH-1));
      case (state)
         IDLE: begin
            if (start && alu_op[3] && !flush) begin
               accept   = 1'b1;
               busy     = 1'b1;
               state_nx = bypass ? FINISH : CALC;
            end
         end
         CALC: begin
            busy      = 1'b1;
            calc_step = !flush;
            if (flush)
               state_nx = IDLE;
            else if (last)
               state_nx = FINISH;
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // RESULT is written on the edge entering FINISH, so it is valid in the DONE cycle.
   assign done = (state == FINISH);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         result <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            count <= '0;
            if (bypass)
               result <= bypass_val;
         end else if (calc_step) begin
            count <= count + 1'b1;
            if (last)
               result <= final_val;
         end
      end
   end

   // NOTE: datapath registers carry no reset; they are always reloaded on accept before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         acc   <= '0;
         lo    <= mag1;
         opb   <= mag2;
         op_q  <= op_in;
         neg_q <= in_neg;
      end else if (calc_step) begin
         acc <= op_q[2] ? div_acc_nx : mul_sum[DATA_WIDTH:1];
         lo  <= op_q[2] ? div_lo_nx  : {mul_sum[0], lo[DATA_WIDTH-1:1]};
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table for result/latency, plus flush, reset and ignore cases.
module tb_muldiv_sequencer;

   localparam logic [4:0] OP_MUL    = 5'b01000;
   localparam logic [4:0] OP_MULH   = 5'b01001;
   localparam logic [4:0] OP_MULHSU = 5'b01010;
   localparam logic [4:0] OP_MULHU  = 5'b01011;
   localparam logic [4:0] OP_DIV    = 5'b01100;
   localparam logic [4:0] OP_DIVU   = 5'b01101;
   localparam logic [4:0] OP_REM    = 5'b01110;
   localparam logic [4:0] OP_REMU   = 5'b01111;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [4:0]  alu_op;
   logic [31:0] data1, data2;
   logic        busy, done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.DATA_WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .alu_op (alu_op),
      .data1  (data1),
      .data2  (data2),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] exp_res;
      int          exp_done;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at posedge+1; cycle 0 is the cycle START is first driven. Samples at each negedge
   // for cycles 0..max_cyc, stopping after the first DONE. Returns at posedge+1 of the next cycle.
   task automatic run_op(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input int flush_at, input int max_cyc, input bit hold,
                         output int done_cyc, output logic [31:0] res, output int busy_cyc);
      done_cyc = -1;
      busy_cyc = 0;
      res      = '0;
      for (int c = 0; c <= max_cyc; c++) begin
         start  = (c == 0) || hold;
         alu_op = op;
         data1  = d1;
         data2  = d2;
         flush  = (c == flush_at);
         @(negedge clk);
         if (busy) busy_cyc++;
         res = result;
         if (done) done_cyc = c;
         @(posedge clk);
         #1;
         if (done_cyc >= 0) break;
      end
      start = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int          dc, bc;
      logic [31:0] r;

      vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
      vecs[2]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
      vecs[3]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
      vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
      vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
      vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2,        33};
      vecs[8]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vecs[9]  = '{OP_REM,    32'd5,        32'd0,        32'd5,        1};
      vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
      vecs[12] = '{OP_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33};
      vecs[13] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
      vecs[14] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
      vecs[15] = '{OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
      vecs[16] = '{OP_DIV,    32'd0,        32'd5,        32'd0,        33};
      vecs[17] = '{OP_MULHU,  32'h80000000, 32'd4,        32'd2,        33};

      reset  = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      alu_op = '0;
      data1  = '0;
      data2  = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset busy",   {31'b0, busy}, 32'd0);
      check("reset done",   {31'b0, done}, 32'd0);
      check("reset result", result,        32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         run_op(vecs[i].op, vecs[i].d1, vecs[i].d2, -1, 40, 1'b0, dc, r, bc);
         check($sformatf("v%0d result", i),     r,          vecs[i].exp_res);
         check($sformatf("v%0d done cycle", i), 32'(dc),    32'(vecs[i].exp_done));
         check($sformatf("v%0d busy cycles", i), 32'(bc),   32'(vecs[i].exp_done));
         @(negedge clk);
         check($sformatf("v%0d done pulse", i), {31'b0, done}, 32'd0);
         check($sformatf("v%0d result hold", i), result,    vecs[i].exp_res);
         @(posedge clk);
         #1;
      end

      // Flush at cycle 10 of a DIV: back in IDLE at cycle 11, no DONE, result unchanged.
      run_op(OP_DIVU, 32'd100, 32'd7, 10, 11, 1'b0, dc, r, bc);
      check("flush no done",     32'(dc), 32'hFFFFFFFF);
      check("flush busy cycles", 32'(bc), 32'd11);
      check("flush result kept", r,       32'd2);
      // Next MUL starts at cycle 12 and completes 33 cycles later (cycle 45).
      run_op(OP_MUL, 32'd3, 32'd5, -1, 40, 1'b0, dc, r, bc);
      check("post flush result",     r,       32'd15);
      check("post flush done cycle", 32'(dc), 32'd33);

      // Flush in FINISH: the op has already retired, so DONE and RESULT still land.
      run_op(OP_MUL, 32'd6, 32'd7, 33, 40, 1'b0, dc, r, bc);
      check("finish flush result",     r,       32'd42);
      check("finish flush done cycle", 32'(dc), 32'd33);

      // START held high through the op: restarts outside IDLE are ignored.
      run_op(OP_MULH, 32'hFFFFFFFD, 32'd5, -1, 40, 1'b1, dc, r, bc);
      check("held start result",     r,       32'hFFFFFFFF);
      check("held start done cycle", 32'(dc), 32'd33);

      // Reset during cycle 5 of a MUL.
      run_op(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 4, 1'b0, dc, r, bc);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid reset busy",   {31'b0, busy}, 32'd0);
      check("mid reset done",   {31'b0, done}, 32'd0);
      check("mid reset result", result,        32'd0);
      @(posedge clk);
      #1;
      run_op(OP_REMU, 32'd100, 32'd7, -1, 40, 1'b0, dc, r, bc);
      check("post reset result",     r,       32'd2);
      check("post reset done cycle", 32'(dc), 32'd33);

      // START with ALU_OP[3]=0 is not an M-extension op.
      run_op(5'b00100, 32'd9, 32'd3, -1, 6, 1'b1, dc, r, bc);
      check("non-M busy", 32'(bc), 32'd0);
      check("non-M done", 32'(dc), 32'hFFFFFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
